// File: rtl/fp_adder_arbiter.sv
// fp_adder_arbiter
//   Shares one pipelined floating-point adder between four requesters.
//   A round-robin arbiter picks at most one request per cycle and registers
//   its operands into add_a/add_b. A tag pipeline of depth ADD_LAT remembers
//   which requester owns each op. When a tag leaves the pipeline, the adder
//   output is captured into resp_* and the owner gets a one-cycle resp_valid
//   pulse, ADD_LAT+1 cycles after its handshake.
//   A drain sequence (RUN -> DRAIN -> HALT) stops new grants, lets in-flight
//   ops finish, then reports drain_done until drain_req is released.
//
//   Optional build macro FP_ARB_NAN_CANON_EN: when defined, any result the
//   adder marks as NaN or error is replaced by the canonical quiet NaN
//   32'h7FC00000. Flags are always passed through untouched.
//
//   Handshake semantics: a request on lane i is accepted in the cycle where
//   req_valid[i] and req_ready[i] are both 1. req_ready is a combinational
//   one-hot grant, is only ever set on a lane that is currently valid, and is
//   zero whenever rst is low or the controller is not in RUN. A requester
//   must hold req_a/req_b for its lane stable while req_valid is high.
//   Responses carry no backpressure: resp_valid is a single-cycle pulse.
//
//   ADD_LAT must be at least 1.

module fp_adder_arbiter #(
  parameter int ADD_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_valid,
  input  logic [127:0] req_a,
  input  logic [127:0] req_b,
  output logic [3:0]   req_ready,
  output logic [31:0]  add_a,
  output logic [31:0]  add_b,
  input  logic [31:0]  add_result,
  input  logic         add_nan,
  input  logic         add_inf,
  input  logic         add_neg_inf,
  input  logic         add_err,
  output logic [3:0]   resp_valid,
  output logic [31:0]  resp_result,
  output logic         resp_nan,
  output logic         resp_inf,
  output logic         resp_neg_inf,
  output logic         resp_err,
  input  logic         drain_req,
  output logic         drain_done,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // Round-robin pointer: the lane searched first in the next grant.
  logic [1:0]  rr_ptr;

  // Grant decode
  logic        gnt_any;
  logic [1:0]  gnt_idx;
  logic [1:0]  cand;
  logic        hs;
  logic [31:0] gnt_a;
  logic [31:0] gnt_b;

  // Tag pipeline: valid bit and owner id per adder stage
  logic [ADD_LAT-1:0] tag_v;
  logic [1:0]         tag_id [ADD_LAT];
  logic               exit_v;
  logic [1:0]         exit_id;

  // Response data selected for capture
  logic [31:0] res_sel;

  // ------------------------------------------------------------------
  // Controller
  // ------------------------------------------------------------------

  // State register; reset returns to RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: drain stops grants, waits for empty pipeline, then
  // holds in HALT until the drain request is withdrawn.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (drain_req) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!busy) begin
          state_next = HALT;
        end
      end
      HALT: begin
        if (!drain_req) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  assign drain_done = (state == HALT);
  assign dbg_state  = state;

  // ------------------------------------------------------------------
  // Arbiter
  // ------------------------------------------------------------------

  // Search lanes starting at rr_ptr and wrapping; a same-cycle drain request
  // suppresses the grant so nothing new enters once draining starts.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    cand    = 2'd0;
    if (rst && (state == RUN) && !drain_req) begin
      for (int k = 0; k < 4; k++) begin
        cand = rr_ptr + 2'(k);
        if (!gnt_any && req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign req_ready = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;
  assign hs        = |(req_valid & req_ready);
  assign gnt_a     = req_a[{gnt_idx, 5'd0} +: 32];
  assign gnt_b     = req_b[{gnt_idx, 5'd0} +: 32];

  // Pointer advances past the winner only when a request is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= 2'd0;
    end else if (hs) begin
      rr_ptr <= gnt_idx + 2'd1;
    end
  end

  // Operand registers feeding the adder; held when nothing is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      add_a <= 32'd0;
      add_b <= 32'd0;
    end else if (hs) begin
      add_a <= gnt_a;
      add_b <= gnt_b;
    end
  end

  // ------------------------------------------------------------------
  // Tag pipeline
  // ------------------------------------------------------------------

  // Shift owner tags in lockstep with the adder so each result can be
  // routed back without the adder knowing about requesters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_v <= '0;
      for (int i = 0; i < ADD_LAT; i++) begin
        tag_id[i] <= 2'd0;
      end
    end else begin
      tag_v[0]  <= hs;
      tag_id[0] <= gnt_idx;
      for (int i = 1; i < ADD_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign exit_v  = tag_v[ADD_LAT-1];
  assign exit_id = tag_id[ADD_LAT-1];
  assign busy    = |tag_v;

  // ------------------------------------------------------------------
  // Response capture
  // ------------------------------------------------------------------

  // Result word to capture, optionally canonicalising NaN/error outcomes.
  always_comb begin
    res_sel = add_result;
`ifdef FP_ARB_NAN_CANON_EN
    if (add_err || add_nan) begin
      res_sel = 32'h7FC0_0000;
    end
`endif
  end

  // One-cycle pulse to the owner of the exiting tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_valid <= 4'b0000;
    end else if (exit_v) begin
      resp_valid <= 4'b0001 << exit_id;
    end else begin
      resp_valid <= 4'b0000;
    end
  end

  // Response data is captured only for an exiting tag and held otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_result  <= 32'd0;
      resp_nan     <= 1'b0;
      resp_inf     <= 1'b0;
      resp_neg_inf <= 1'b0;
      resp_err     <= 1'b0;
    end else if (exit_v) begin
      resp_result  <= res_sel;
      resp_nan     <= add_nan;
      resp_inf     <= add_inf;
      resp_neg_inf <= add_neg_inf;
      resp_err     <= add_err;
    end
  end

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// tb_fp_adder_arbiter
//   Bench for fp_adder_arbiter. An adder stand-in produces results from a
//   small table of known vectors plus a scrambling rule for everything else.
//   A reference model tracks the arbitration order, the drain sequence and
//   an expected-response queue, and is compared with the DUT every cycle.

module tb_fp_adder_arbiter;

  localparam int ADD_LAT = 2;
  localparam int W       = 70;  // {due[31:0], id[1:0], result[31:0], flags[3:0]}

`ifdef FP_ARB_NAN_CANON_EN
  localparam logic [31:0] NAN_RES = 32'h7FC0_0000;
`else
  localparam logic [31:0] NAN_RES = 32'h7F80_0002;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic [31:0]  add_a;
  logic [31:0]  add_b;
  logic [31:0]  add_result;
  logic         add_nan, add_inf, add_neg_inf, add_err;
  logic [3:0]   resp_valid;
  logic [31:0]  resp_result;
  logic         resp_nan, resp_inf, resp_neg_inf, resp_err;
  logic         drain_req;
  logic         drain_done;
  logic         busy;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  fp_adder_arbiter #(.ADD_LAT(ADD_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_result   (add_result),
    .add_nan      (add_nan),
    .add_inf      (add_inf),
    .add_neg_inf  (add_neg_inf),
    .add_err      (add_err),
    .resp_valid   (resp_valid),
    .resp_result  (resp_result),
    .resp_nan     (resp_nan),
    .resp_inf     (resp_inf),
    .resp_neg_inf (resp_neg_inf),
    .resp_err     (resp_err),
    .drain_req    (drain_req),
    .drain_done   (drain_done),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- adder stand-in ----------------
  // Returns {result, nan, inf, neg_inf, err}.
  function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [35:0] r;
    case ({a, b})
      {32'h43663BE7, 32'h4728F8E0}: r = {32'h4729DF1B, 4'b0000};
      {32'h7F800000, 32'h7F000008}: r = {32'h7F800000, 4'b0100};
      {32'h7F800002, 32'h7F800001}: r = {32'h7F800002, 4'b1001};
      {32'hC3663BE7, 32'h43663BE7}: r = {32'h00000000, 4'b0000};
      default: r = {a ^ {b[15:0], b[31:16]}, a[0] & b[1], a[2] & b[3], a[4] & b[5], a[6] & b[7]};
    endcase
    return r;
  endfunction

  // What the requester should see for a given operand pair.
  function automatic logic [35:0] exp_resp(input logic [31:0] a, input logic [31:0] b);
    logic [35:0] r;
    r = ref_add(a, b);
`ifdef FP_ARB_NAN_CANON_EN
    if (r[3] || r[0]) r[35:4] = 32'h7FC0_0000;
`endif
    return r;
  endfunction

  // The adder registers its inputs ADD_LAT-1 times (ADD_LAT >= 2 here).
  logic [35:0] stub_pipe [ADD_LAT-1];
  always @(posedge clk) begin
    stub_pipe[0] <= ref_add(add_a, add_b);
    for (int i = 1; i < ADD_LAT - 1; i++) stub_pipe[i] <= stub_pipe[i-1];
  end
  assign {add_result, add_nan, add_inf, add_neg_inf, add_err} = stub_pipe[ADD_LAT-2];

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  int            mode = 0;          // 0 run, 1 drain, 2 halt
  int            ptr  = 0;
  logic [31:0]   exp_add_a = 32'd0;
  logic [31:0]   exp_add_b = 32'd0;
  logic [35:0]   last_resp = 36'd0;
  int unsigned   n = 0;
  bit            mon_en = 1'b0;

  // Observation logs used by directed checks.
  int            gnt_log[$];
  logic [37:0]   resp_log[$];
  int unsigned   last_hs_cycle = 0;
  int unsigned   last_resp_cycle = 0;
  bit            drain_seen = 1'b0;

  int            m_g;
  logic [3:0]    m_ready;
  logic [3:0]    m_rv;
  logic [35:0]   m_data;
  logic [W-1:0]  m_e;
  bit            m_busy;
  logic [31:0]   m_a, m_b;

  // Per-cycle comparison against the model, then model advance.
  always @(negedge clk) begin
    if (mon_en) begin
      // expected grant: first valid lane at or after ptr, only in RUN
      m_g = -1;
      if (rst && mode == 0 && !drain_req) begin
        for (int k = 0; k < 4; k++) begin
          if (m_g < 0 && req_valid[(ptr + k) % 4]) m_g = (ptr + k) % 4;
        end
      end
      m_ready = (m_g >= 0) ? 4'(1 << m_g) : 4'b0000;
      check("req_ready", 64'(req_ready), 64'(m_ready));

      // expected response this cycle
      m_rv   = 4'b0000;
      m_data = last_resp;
      if (exp_q.size() > 0 && exp_q[0][69:38] == n) begin
        m_e       = exp_q.pop_front();
        m_rv      = 4'(1 << m_e[37:36]);
        m_data    = m_e[35:0];
        last_resp = m_e[35:0];
      end
      check("resp_valid", 64'(resp_valid), 64'(m_rv));
      check("resp_data", 64'({resp_result, resp_nan, resp_inf, resp_neg_inf, resp_err}), 64'(m_data));

      m_busy = (exp_q.size() > 0);
      check("busy", 64'(busy), 64'(m_busy));
      check("drain_done", 64'(drain_done), 64'(mode == 2));
      check("add_a", 64'(add_a), 64'(exp_add_a));
      check("add_b", 64'(add_b), 64'(exp_add_b));

      // observation logs
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          gnt_log.push_back(i);
          last_hs_cycle = n;
        end
        if (resp_valid[i]) begin
          resp_log.push_back({2'(i), resp_result, resp_nan, resp_inf, resp_neg_inf, resp_err});
          last_resp_cycle = n;
        end
      end
      if (drain_done && !busy) drain_seen = 1'b1;

      // advance model to the state after the coming rising edge
      if (!rst) begin
        exp_q.delete();
        mode      = 0;
        ptr       = 0;
        exp_add_a = 32'd0;
        exp_add_b = 32'd0;
        last_resp = 36'd0;
      end else begin
        if (m_g >= 0) begin
          m_a = req_a[m_g*32 +: 32];
          m_b = req_b[m_g*32 +: 32];
          exp_q.push_back({32'(n + ADD_LAT + 1), 2'(m_g), exp_resp(m_a, m_b)});
          exp_add_a = m_a;
          exp_add_b = m_b;
          ptr       = (m_g + 1) % 4;
        end
        case (mode)
          0: if (drain_req) mode = 1;
          1: if (!m_busy) mode = 2;
          2: if (!drain_req) mode = 0;
          default: mode = 0;
        endcase
      end
    end
    n++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) set_op(i, $urandom, $urandom);
  endtask

  task automatic idle(input int cycles);
    req_valid = 4'b0000;
    drain_req = 1'b0;
    repeat (cycles) tick();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    repeat (cycles) tick();
    rst = 1'b1;
  endtask

  function automatic logic [37:0] log_at(input int k);
    return (resp_log.size() > k) ? resp_log[k] : 38'h3F_FFFF_FFFF;
  endfunction

  function automatic int gnt_at(input int k);
    return (gnt_log.size() > k) ? gnt_log[k] : 99;
  endfunction

  int exp_seq[5] = '{0, 1, 2, 3, 0};
  int drain_cnt;
  int pick;

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b0;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    drain_req = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // single op on requester 2
    resp_log.delete();
    req_valid = 4'b0100;
    set_op(2, 32'h43663BE7, 32'h4728F8E0);
    tick();
    idle(6);
    check("single_id_data", 64'(log_at(0)), 64'({2'd2, 32'h4729DF1B, 4'b0000}));
    check("single_latency", 64'(last_resp_cycle - last_hs_cycle), 64'(ADD_LAT + 1));

    // contention from reset
    do_reset(2);
    gnt_log.delete();
    resp_log.delete();
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      rand_ops();
      tick();
    end
    idle(6);
    for (int k = 0; k < 5; k++) begin
      check("cont_grant", 64'(gnt_at(k)), 64'(exp_seq[k]));
      check("cont_resp_id", 64'(log_at(k) >> 36), 64'(exp_seq[k]));
    end

    // flag vectors and cancellation, back to back on requester 1
    resp_log.delete();
    req_valid = 4'b0010;
    set_op(1, 32'h7F800000, 32'h7F000008);
    tick();
    set_op(1, 32'h7F800002, 32'h7F800001);
    tick();
    set_op(1, 32'hC3663BE7, 32'h43663BE7);
    tick();
    idle(6);
    check("flag_inf", 64'(log_at(0)), 64'({2'd1, 32'h7F800000, 4'b0100}));
    check("flag_nan", 64'(log_at(1)), 64'({2'd1, NAN_RES, 4'b1001}));
    check("cancel", 64'(log_at(2)), 64'({2'd1, 32'h00000000, 4'b0000}));

    // drain with a competing third request
    gnt_log.delete();
    resp_log.delete();
    drain_seen = 1'b0;
    rand_ops();
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1000;
    drain_req = 1'b1;
    repeat (7) tick();
    drain_req = 1'b0;
    repeat (2) tick();
    idle(6);
    check("drain_grants", 64'(gnt_log.size()), 64'd3);
    check("drain_third", 64'(gnt_at(2)), 64'd3);
    check("drain_resps", 64'(resp_log.size()), 64'd3);
    check("drain_done_seen", 64'(drain_seen), 64'd1);

    // reset one cycle after a handshake
    resp_log.delete();
    rand_ops();
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b1111;
    do_reset(1);
    idle(6);
    check("rst_drop", 64'(resp_log.size()), 64'd0);

    // randomized traffic with occasional drains and resets
    drain_cnt = 0;
    for (int c = 0; c < 500; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      rand_ops();
      pick = $urandom_range(0, 15);
      if (pick == 0) set_op($urandom_range(0, 3), 32'h7F800002, 32'h7F800001);
      if (pick == 1) set_op($urandom_range(0, 3), 32'h7F800000, 32'h7F000008);
      if (drain_cnt > 0) begin
        drain_req = 1'b1;
        drain_cnt--;
      end else begin
        drain_req = 1'b0;
        if ($urandom_range(0, 40) == 0) drain_cnt = $urandom_range(2, 8);
      end
      rst = ($urandom_range(0, 80) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst = 1'b1;
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_adder_arbiter.md
FP_ADDER_ARBITER -- requirements
Module: fp_adder_arbiter

Interface
REQ-001 SHALL have parameter: ADD_LAT, default 2, cycles from add_a/add_b update to valid add_result/flags.
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: req_valid  in  4  per-requester operation request.
REQ-005 SHALL have port: req_a  in  128  operand A, requester i in bits [32i+31:32i].
REQ-006 SHALL have port: req_b  in  128  operand B, same packing.
REQ-007 SHALL have port: req_ready  out  4  one-hot grant; handshake = req_valid[i] & req_ready[i].
REQ-008 SHALL have port: add_a, add_b  out  32 each  registered operands to floating_point_adder a_reg/b_reg.
REQ-009 SHALL have port: add_result  in  32; add_nan, add_inf, add_neg_inf, add_err  in  1 each  adder outputs.
REQ-010 SHALL have port: resp_valid  out  4  one-hot, one-cycle response pulse to owning requester.
REQ-011 SHALL have port: resp_result  out  32; resp_nan, resp_inf, resp_neg_inf, resp_err  out  1 each  registered response data.
REQ-012 SHALL have port: drain_req  in  1; drain_done  out  1; busy  out  1  (any op in flight).

Function
REQ-013 SHALL use FSM states RUN, DRAIN, HALT; req_ready nonzero only in RUN.
REQ-014 SHALL, in RUN, grant the first valid requester at or after rr_ptr (wrapping 3->0), combinationally; no grant if no valid.
REQ-015 SHALL set rr_ptr to (granted index + 1) mod 4 on each handshake; unchanged otherwise.
REQ-016 SHALL on handshake load add_a/add_b with the granted operands; otherwise hold them.
REQ-017 SHALL accept at most one handshake per cycle, fully pipelined (new issue every cycle permitted).
REQ-018 SHALL track each op in a tag pipeline of depth ADD_LAT: {valid, 2-bit requester id}.
REQ-019 SHALL, when the tag exits the pipeline, register add_result/flags into resp_* and pulse resp_valid[id] high one cycle.
REQ-020 SHALL give fixed latency: resp_valid high exactly ADD_LAT+1 cycles after the handshake cycle (3 at default).
REQ-021 SHALL keep resp_valid 0 in cycles with no exiting tag; resp_result/flags hold last value.
REQ-022 SHALL assert busy when any tag valid bit is 1.
REQ-023 SHALL transition RUN->DRAIN when drain_req=1; drain_req wins over a same-cycle request (no grant).
REQ-024 SHALL transition DRAIN->HALT when busy=0; in-flight ops still complete and respond during DRAIN.
REQ-025 SHALL assert drain_done=1 only in HALT; HALT->RUN when drain_req=0.
REQ-026 SHALL not drop, duplicate, or reorder responses; responses return in issue order.
REQ-027 SHALL never treat add_* flags as handshakes; flags are passed through with the owning result.

Reset
REQ-028 SHALL, when rst=0 at a rising edge: state=RUN, rr_ptr=0, tag pipeline cleared, add_a=add_b=0, resp_result=0, all resp flags=0, resp_valid=0, drain_done=0, busy=0.
REQ-029 SHALL drop ops in flight at reset; no resp_valid for them after reset release.
REQ-030 SHALL drive req_ready=0 while rst=0.

Configuration
REQ-031 SHALL support macro FP_ARB_NAN_CANON_EN: defined -> when add_err=1 or add_nan=1, resp_result=32'h7FC00000; undefined -> resp_result=add_result unmodified. Flags are unaffected either way.

Verification
REQ-032 SHALL test single op: requester 2 sends 43663BE7 + 4728F8E0 -> resp_valid=4'b0100 3 cycles later, resp_result=4729DF1B, flags 0.
REQ-033 SHALL test contention: all 4 valid continuously from reset -> grants 0,1,2,3,0 on consecutive cycles; responses in same order, 3-cycle lag.
REQ-034 SHALL test flags: 7F800000 + 7F000008 -> resp_result=7F800000, resp_inf=1; 7F800002 + 7F800001 -> resp_err=1, resp_nan=1, resp_result=7FC00000 only with FP_ARB_NAN_CANON_EN.
REQ-035 SHALL test drain: issue 2 back-to-back ops, assert drain_req same cycle as a third request -> third not granted, both responses delivered, drain_done=1 after busy=0, grants resume after drain_req=0.
REQ-036 SHALL test reset mid-flight: rst=0 one cycle after a handshake -> no resp_valid ever for that op, all outputs at reset values.
REQ-037 SHALL test cancellation: C3663BE7 + 43663BE7 -> resp_result=00000000, all flags 0.
